// File: rtl/uart_ctrl_pkg.sv
// Shared encodings for the digest-to-UART sequencer: FSM states and ASCII constants.
package uart_ctrl_pkg;
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_WAIT_REL  = 2'd3;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    IDLE      = S_IDLE,
    LOAD      = S_LOAD,
    WAIT_DONE = S_WAIT_DONE,
    WAIT_REL  = S_WAIT_REL
  } state_t;
endpackage

// File: rtl/uart_digest_sender_if.sv
// Byte-level handshake between the digest sequencer and the UART transmitter.
interface uart_digest_sender_if;
  logic       Tx_DV_out;
  logic [7:0] Tx_Byte_out;
  logic       Tx_Done_in;

  modport master (output Tx_DV_out, output Tx_Byte_out, input Tx_Done_in);
  modport slave  (input Tx_DV_out, input Tx_Byte_out, output Tx_Done_in);
endinterface

// File: rtl/uart_digest_sender_nibble_to_ascii.sv
// Maps one 4-bit value to its upper-case ASCII hex character.
module nibble_to_ascii
  import uart_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] chr
);
  always_comb begin
    if (nib < 4'd10) chr = ASCII_0 + {4'h0, nib};
    else             chr = ASCII_A + {4'h0, nib} - 8'd10;
  end
endmodule

// File: rtl/uart_digest_sender.sv
// Streams a captured digest MSB byte first through the UART byte interface,
// optionally as ASCII hex with a trailing CR LF, pacing on the transmitter done level.
module uart_digest_sender
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_BYTES = 32,
  parameter int ASCII_HEX = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   Start_in,
  input  logic [NUM_BYTES*8-1:0] Digest_in,
  output logic                   Busy_out,
  output logic                   Done_out,
  uart_digest_sender_if.master   tx
);
  localparam int DW    = NUM_BYTES * 8;
  localparam int TOTAL = (ASCII_HEX != 0) ? 2 * NUM_BYTES + 2 : NUM_BYTES;
  localparam int CW    = $clog2(TOTAL + 1);

  state_t          state, state_nxt;
  logic [DW-1:0]   digest_q, src;
  logic [CW-1:0]   char_cnt, cnt_inc, idx_nxt;
  logic [7:0]      byte_q, char_nxt;
  logic            done_q, done_nxt, adv, last;

  assign cnt_inc = char_cnt + 1'b1;
  assign last    = (char_cnt == CW'(TOTAL - 1));

  // The character register is loaded on the edge entering LOAD, so it is
  // computed from the values that will hold in LOAD: on a start that is the
  // raw input digest at index 0, otherwise the stored digest at count+1.
  assign src     = (state == IDLE) ? Digest_in : digest_q;
  assign idx_nxt = (state == IDLE) ? '0 : cnt_inc;

  generate
    if (ASCII_HEX != 0) begin : g_hex
      logic [7:0] byte_sel, hex_chr;
      logic [3:0] nib;
      assign byte_sel = src[(NUM_BYTES - 1 - int'(idx_nxt >> 1)) * 8 +: 8];
      assign nib      = idx_nxt[0] ? byte_sel[3:0] : byte_sel[7:4];
      nibble_to_ascii u_n2a (.nib(nib), .chr(hex_chr));
      assign char_nxt = (idx_nxt == CW'(2 * NUM_BYTES))     ? ASCII_CR :
                        (idx_nxt == CW'(2 * NUM_BYTES + 1)) ? ASCII_LF : hex_chr;
    end else begin : g_raw
      assign char_nxt = src[(NUM_BYTES - 1 - int'(idx_nxt)) * 8 +: 8];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      digest_q <= '0;
      char_cnt <= '0;
      byte_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (state == IDLE && Start_in) begin
        digest_q <= Digest_in;
        char_cnt <= '0;
      end else if (adv) begin
        char_cnt <= cnt_inc;
      end
      if (state_nxt == LOAD) byte_q <= char_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE:      if (Start_in) state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx.Tx_Done_in) state_nxt = WAIT_REL;
      // Done stays high through the transmitter's cleanup cycle; a new
      // data-valid is only safe once it has dropped.
      WAIT_REL: begin
        if (!tx.Tx_Done_in) begin
          adv = 1'b1;
          if (last) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  assign tx.Tx_DV_out   = (state == LOAD);
  assign tx.Tx_Byte_out = byte_q;
  assign Busy_out       = (state != IDLE);
  assign Done_out       = done_q;
endmodule

// File: tb/tb_uart_digest_sender.sv
// Directed bench: raw and hex senders each drive a behavioural UART transmitter
// (4 clocks per bit); a line monitor decodes frames and pacing is tracked per cycle.
module tb_uart_digest_sender;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   start;
  logic [255:0] dig0, dig1, da, db;
  logic [1:0]   busy_w, done_w, dv_w;
  logic [1:0]   tdone = 2'b00;
  logic [1:0]   line  = 2'b11;
  logic [7:0]   byte_w [2];

  uart_digest_sender_if txi0 ();
  uart_digest_sender_if txi1 ();

  uart_digest_sender #(.NUM_BYTES(32), .ASCII_HEX(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .Start_in(start[0]), .Digest_in(dig0),
    .Busy_out(busy_w[0]), .Done_out(done_w[0]), .tx(txi0.master));
  uart_digest_sender #(.NUM_BYTES(32), .ASCII_HEX(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .Start_in(start[1]), .Digest_in(dig1),
    .Busy_out(busy_w[1]), .Done_out(done_w[1]), .tx(txi1.master));

  assign dv_w[0]   = txi0.Tx_DV_out;
  assign dv_w[1]   = txi1.Tx_DV_out;
  assign byte_w[0] = txi0.Tx_Byte_out;
  assign byte_w[1] = txi1.Tx_Byte_out;
  assign txi0.Tx_Done_in = tdone[0];
  assign txi1.Tx_Done_in = tdone[1];

  // Transmitter model: done rises at the end of the stop bit and stays high
  // through a cleanup cycle plus the first idle cycle; data-valid is ignored in cleanup.
  int         tst [2] = '{0, 0};
  int         tcnt[2] = '{0, 0};
  int         tbi [2] = '{0, 0};
  logic [7:0] tsh [2];
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      case (tst[u])
        0: begin
          line[u] <= 1'b1; tdone[u] <= 1'b0; tcnt[u] <= 0;
          if (dv_w[u]) begin tsh[u] <= byte_w[u]; tst[u] <= 1; end
        end
        1: begin
          line[u] <= 1'b0;
          if (tcnt[u] < 3) tcnt[u] <= tcnt[u] + 1;
          else begin tcnt[u] <= 0; tbi[u] <= 0; tst[u] <= 2; end
        end
        2: begin
          line[u] <= tsh[u][tbi[u]];
          if (tcnt[u] < 3) tcnt[u] <= tcnt[u] + 1;
          else begin
            tcnt[u] <= 0;
            if (tbi[u] < 7) tbi[u] <= tbi[u] + 1; else tst[u] <= 3;
          end
        end
        3: begin
          line[u] <= 1'b1;
          if (tcnt[u] < 3) tcnt[u] <= tcnt[u] + 1;
          else begin tdone[u] <= 1'b1; tst[u] <= 4; end
        end
        default: tst[u] <= 0;
      endcase
    end
  end

  // Line monitor and per-cycle pacing bookkeeping.
  logic [7:0] rxq0[$], rxq1[$];
  logic [1:0] rcv = 2'b00, tdone_q = 2'b00, lat_pend = 2'b00;
  int         mc[2]       = '{0, 0};
  logic [7:0] rsh[2];
  int         ndv[2]      = '{0, 0};
  int         ndone[2]    = '{0, 0};
  int         pace_err[2] = '{0, 0};
  int         lat_err[2]  = '{0, 0};
  int         frm_err[2]  = '{0, 0};
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rcv[u]) begin
        mc[u] <= mc[u] + 1;
        if (mc[u] + 1 >= 6 && mc[u] + 1 <= 34 && ((mc[u] + 1 - 6) % 4) == 0)
          rsh[u] <= {line[u], rsh[u][7:1]};
        if (mc[u] + 1 == 38) begin
          rcv[u] <= 1'b0;
          if (!line[u]) frm_err[u] <= frm_err[u] + 1;
          if (u == 0) rxq0.push_back(rsh[u]); else rxq1.push_back(rsh[u]);
        end
      end else if (!line[u]) begin
        rcv[u] <= 1'b1;
        mc[u]  <= 0;
      end
      if (dv_w[u] && (tdone_q[u] || tst[u] != 0)) pace_err[u] <= pace_err[u] + 1;
      if (lat_pend[u] && !(dv_w[u] || done_w[u])) lat_err[u] <= lat_err[u] + 1;
      lat_pend[u] <= tdone_q[u] && !tdone[u] && busy_w[u];
      tdone_q[u]  <= tdone[u];
      if (dv_w[u])   ndv[u]   <= ndv[u] + 1;
      if (done_w[u]) ndone[u] <= ndone[u] + 1;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int u, input string tag);
    int k;
    k = 0;
    while (k < 6000 && !done_w[u]) begin tick(); k++; end
    chk(tag, 32'(done_w[u]), 1);
  endtask

  function automatic logic [7:0] hex_exp(input int i);
    if (i == 0)  return 8'h41;
    if (i == 1)  return 8'h42;
    if (i < 62)  return 8'h30;
    if (i < 64)  return 8'h46;
    if (i == 64) return 8'h0D;
    return 8'h0A;
  endfunction

  int b_rx, b_dv, b_dn, k;

  initial begin
    rst_n = 1'b0; start = 2'b00; dig0 = '0; dig1 = '0;
    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      chk("rst_busy", 32'(busy_w[u]), 0);
      chk("rst_done", 32'(done_w[u]), 0);
      chk("rst_dv",   32'(dv_w[u]),   0);
      chk("rst_byte", 32'(byte_w[u]), 0);
    end
    rst_n = 1'b1;
    tick();

    // Raw send of 00..1F, with an ignored mid-transfer restart
    for (int i = 0; i < 32; i++) da[(31 - i) * 8 +: 8] = 8'(i);
    for (int i = 0; i < 32; i++) db[(31 - i) * 8 +: 8] = 8'(8'hC0 + i);
    b_rx = rxq0.size(); b_dv = ndv[0]; b_dn = ndone[0];
    dig0 = da; start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("raw_first_dv", 32'(dv_w[0]), 1);
    chk("raw_busy", 32'(busy_w[0]), 1);
    repeat (150) tick();
    dig0 = '1; start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("raw_busy_mid", 32'(busy_w[0]), 1);
    wait_done(0, "raw_done");
    chk("raw_busy_at_done", 32'(busy_w[0]), 0);
    chk("raw_rx_count_at_done", 32'(rxq0.size() - b_rx), 32);
    chk("raw_dv_count", 32'(ndv[0] - b_dv), 32);
    chk("raw_done_count", 32'(ndone[0] - b_dn), 1);
    for (int i = 0; i < 32; i++) chk("raw_data", 32'(rxq0[b_rx + i]), i);

    // Start in the Done_out cycle begins the next transfer immediately
    b_rx = rxq0.size(); b_dv = ndv[0]; b_dn = ndone[0];
    dig0 = db; start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("b2b_first_dv", 32'(dv_w[0]), 1);
    chk("b2b_first_byte", 32'(byte_w[0]), 32'hC0);
    wait_done(0, "b2b_done");
    chk("b2b_dv_count", 32'(ndv[0] - b_dv), 32);
    chk("b2b_done_count", 32'(ndone[0] - b_dn), 1);
    for (int i = 0; i < 32; i++) chk("b2b_data", 32'(rxq0[b_rx + i]), 32'hC0 + i);
    tick();

    // Reset during byte 5
    b_rx = rxq0.size(); b_dv = ndv[0]; b_dn = ndone[0];
    dig0 = da; start[0] = 1'b1; tick(); start[0] = 1'b0;
    k = 0;
    while (k < 2000 && (ndv[0] - b_dv) < 5) begin tick(); k++; end
    chk("rst_mid_dv5", 32'(ndv[0] - b_dv), 5);
    repeat (10) tick();
    chk("rst_mid_byte_before", 32'(byte_w[0]), 4);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_mid_busy", 32'(busy_w[0]), 0);
    chk("rst_mid_dv",   32'(dv_w[0]),   0);
    chk("rst_mid_done", 32'(done_w[0]), 0);
    chk("rst_mid_byte", 32'(byte_w[0]), 0);
    repeat (150) tick();
    chk("rst_mid_no_done", 32'(ndone[0] - b_dn), 0);
    chk("rst_mid_frames", 32'(rxq0.size() - b_rx), 5);

    b_rx = rxq0.size(); b_dv = ndv[0];
    dig0 = da; start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("post_rst_first_dv", 32'(dv_w[0]), 1);
    wait_done(0, "post_rst_done");
    chk("post_rst_dv_count", 32'(ndv[0] - b_dv), 32);
    for (int i = 0; i < 32; i++) chk("post_rst_data", 32'(rxq0[b_rx + i]), i);

    // Hex send of AB 00.. 00 FF
    b_rx = rxq1.size(); b_dv = ndv[1]; b_dn = ndone[1];
    dig1 = {8'hAB, 240'h0, 8'hFF}; start[1] = 1'b1; tick(); start[1] = 1'b0;
    chk("hex_first_dv", 32'(dv_w[1]), 1);
    chk("hex_first_byte", 32'(byte_w[1]), 32'h41);
    wait_done(1, "hex_done");
    chk("hex_busy_at_done", 32'(busy_w[1]), 0);
    chk("hex_dv_count", 32'(ndv[1] - b_dv), 66);
    chk("hex_done_count", 32'(ndone[1] - b_dn), 1);
    chk("hex_rx_count", 32'(rxq1.size() - b_rx), 66);
    for (int i = 0; i < 66; i++) chk("hex_data", 32'(rxq1[b_rx + i]), 32'(hex_exp(i)));

    repeat (5) tick();
    for (int u = 0; u < 2; u++) begin
      chk("pacing_errors", 32'(pace_err[u]), 0);
      chk("fall_to_dv_latency_errors", 32'(lat_err[u]), 0);
      chk("framing_errors", 32'(frm_err[u]), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
